// File: rtl/stage_cfg_ctrl.sv
// Per-stage configuration write controller: drains in-flight PHVs, then commits one
// key-offset, lookup-CAM or action-RAM entry and reports completion.
module stage_cfg_ctrl #(
  parameter int STAGE   = 0,
  parameter int KEY_LEN = 197,
  parameter int KEY_OFF = 18,
  parameter int ACT_LEN = 25
) (
  input  logic                     axis_clk,
  input  logic                     aresetn,
  // cfg_valid/cfg_ready: a command transfers on the rising edge where both are 1;
  // cfg_valid may be raised at any time, cfg_ready is 1 only while the FSM is IDLE.
  input  logic                     cfg_valid,
  output logic                     cfg_ready,
  input  logic [2:0]               cfg_stage,
  input  logic [1:0]               cfg_target,
  input  logic [4:0]               cfg_addr,
  input  logic [ACT_LEN*25-1:0]    cfg_data,
  input  logic [KEY_LEN-1:0]       cfg_mask,
  output logic                     cfg_done,
  output logic                     cfg_err,
  input  logic                     phv_in_valid,
  input  logic                     phv_out_valid,
  output logic                     phv_hold,
  output logic [KEY_OFF-1:0]       key_off_entry_out,
  output logic [4:0]               key_off_entry_addr,
  output logic                     key_off_entry_valid,
  output logic [KEY_LEN-1:0]       lookup_din,
  output logic [KEY_LEN-1:0]       lookup_din_mask,
  output logic [4:0]               lookup_din_addr,
  output logic                     lookup_din_en,
  output logic [ACT_LEN*25-1:0]    action_data_out,
  output logic [4:0]               action_addr,
  output logic                     action_en,
  output logic [15:0]              wr_count,
  output logic [1:0]               state_dbg
);

  localparam logic [2:0] STAGE_ID = 3'(STAGE);

  typedef enum logic [1:0] {S_IDLE, S_DRAIN, S_WRITE, S_DONE} state_t;

  state_t                  state, state_next;
  logic [3:0]              in_flight;
  logic [1:0]              lat_tgt;
  logic [4:0]              lat_addr;
  logic [ACT_LEN*25-1:0]   lat_data;
  logic [KEY_LEN-1:0]      lat_mask;
  logic                    accept, stage_hit, drain_done;

  assign accept     = cfg_valid && (state == S_IDLE);
  assign stage_hit  = (cfg_stage == STAGE_ID);
  assign drain_done = (state == S_DRAIN) && (in_flight == 4'd0) && !phv_in_valid;
  assign state_dbg  = state;

  always_comb begin
    state_next = state;
    cfg_ready  = 1'b0;
    phv_hold   = 1'b1;
    cfg_done   = 1'b0;
    case (state)
      S_IDLE: begin
        cfg_ready = 1'b1;
        phv_hold  = 1'b0;
        if (accept && stage_hit && cfg_target != 2'd3) state_next = S_DRAIN;
      end
      S_DRAIN: if (drain_done) state_next = S_WRITE;
      S_WRITE: state_next = S_DONE;
      S_DONE: begin
        cfg_done   = 1'b1;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Strobes are decoded from WRITE; their buses were loaded on the DRAIN->WRITE edge.
  assign key_off_entry_valid = (state == S_WRITE) && (lat_tgt == 2'd0);
  assign lookup_din_en       = (state == S_WRITE) && (lat_tgt == 2'd1);
  assign action_en           = (state == S_WRITE) && (lat_tgt == 2'd2);

  always_ff @(posedge axis_clk or negedge aresetn) begin
    if (!aresetn) begin
      state   <= S_IDLE;
      cfg_err <= 1'b0;
    end else begin
      state   <= state_next;
      cfg_err <= accept && stage_hit && (cfg_target == 2'd3);
    end
  end

  always_ff @(posedge axis_clk or negedge aresetn) begin
    if (!aresetn) begin
      in_flight <= 4'd0;
    end else begin
      case ({phv_in_valid, phv_out_valid})
        2'b10:   if (in_flight != 4'd15) in_flight <= in_flight + 4'd1;
        2'b01:   if (in_flight != 4'd0)  in_flight <= in_flight - 4'd1;
        default: in_flight <= in_flight;
      endcase
    end
  end

  // Commands for other stages never touch the latches, so nothing visible changes.
  always_ff @(posedge axis_clk or negedge aresetn) begin
    if (!aresetn) begin
      lat_tgt  <= 2'd0;
      lat_addr <= 5'd0;
      lat_data <= '0;
      lat_mask <= '0;
    end else if (accept && stage_hit) begin
      lat_tgt  <= cfg_target;
      lat_addr <= cfg_addr;
      lat_data <= cfg_data;
      lat_mask <= cfg_mask;
    end
  end

  always_ff @(posedge axis_clk or negedge aresetn) begin
    if (!aresetn) begin
      key_off_entry_out  <= '0;
      key_off_entry_addr <= 5'd0;
      lookup_din         <= '0;
      lookup_din_mask    <= '0;
      lookup_din_addr    <= 5'd0;
      action_data_out    <= '0;
      action_addr        <= 5'd0;
    end else if (drain_done) begin
      case (lat_tgt)
        2'd0: begin
          key_off_entry_out  <= lat_data[KEY_OFF-1:0];
          key_off_entry_addr <= lat_addr;
        end
        2'd1: begin
          lookup_din      <= lat_data[KEY_LEN-1:0];
          lookup_din_mask <= lat_mask;
          lookup_din_addr <= lat_addr;
        end
        2'd2: begin
          action_data_out <= lat_data;
          action_addr     <= lat_addr;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge axis_clk or negedge aresetn) begin
    if (!aresetn) begin
      wr_count <= 16'd0;
    end else if (state == S_DONE) begin
      wr_count <= wr_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_stage_cfg_ctrl.sv
// Self-checking bench for stage_cfg_ctrl (STAGE=2): scoreboarded write records plus
// per-scenario timing checks.
module tb_stage_cfg_ctrl;

  localparam int KEY_LEN = 197;
  localparam int KEY_OFF = 18;
  localparam int ACT_LEN = 25;
  localparam int ACT_W   = ACT_LEN * 25;
  localparam int EXP_W   = 2 + 5 + ACT_W + KEY_LEN;

  logic               axis_clk, aresetn;
  logic               cfg_valid, cfg_ready;
  logic [2:0]         cfg_stage;
  logic [1:0]         cfg_target;
  logic [4:0]         cfg_addr;
  logic [ACT_W-1:0]   cfg_data;
  logic [KEY_LEN-1:0] cfg_mask;
  logic               cfg_done, cfg_err;
  logic               phv_in_valid, phv_out_valid, phv_hold;
  logic [KEY_OFF-1:0] key_off_entry_out;
  logic [4:0]         key_off_entry_addr;
  logic               key_off_entry_valid;
  logic [KEY_LEN-1:0] lookup_din, lookup_din_mask;
  logic [4:0]         lookup_din_addr;
  logic               lookup_din_en;
  logic [ACT_W-1:0]   action_data_out;
  logic [4:0]         action_addr;
  logic               action_en;
  logic [15:0]        wr_count;
  logic [1:0]         state_dbg;

  int errors = 0;
  int checks = 0;
  int exp_wr = 0;
  logic [EXP_W-1:0] exp_q[$];
  logic [EXP_W-1:0] obs_rec, exp_rec;
  logic [ACT_W-1:0] last_act_data;

  stage_cfg_ctrl #(.STAGE(2), .KEY_LEN(KEY_LEN), .KEY_OFF(KEY_OFF), .ACT_LEN(ACT_LEN)) dut (
    .axis_clk(axis_clk), .aresetn(aresetn),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_stage(cfg_stage),
    .cfg_target(cfg_target), .cfg_addr(cfg_addr), .cfg_data(cfg_data), .cfg_mask(cfg_mask),
    .cfg_done(cfg_done), .cfg_err(cfg_err),
    .phv_in_valid(phv_in_valid), .phv_out_valid(phv_out_valid), .phv_hold(phv_hold),
    .key_off_entry_out(key_off_entry_out), .key_off_entry_addr(key_off_entry_addr),
    .key_off_entry_valid(key_off_entry_valid),
    .lookup_din(lookup_din), .lookup_din_mask(lookup_din_mask),
    .lookup_din_addr(lookup_din_addr), .lookup_din_en(lookup_din_en),
    .action_data_out(action_data_out), .action_addr(action_addr), .action_en(action_en),
    .wr_count(wr_count), .state_dbg(state_dbg)
  );

  // Clock and watchdog
  initial begin
    axis_clk = 1'b0;
    forever #5 axis_clk = ~axis_clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  function automatic logic [ACT_W-1:0] rand_data();
    logic [ACT_W-1:0] d;
    for (int i = 0; i < ACT_W; i++) d[i] = 1'($urandom_range(0, 1));
    return d;
  endfunction

  function automatic logic [KEY_LEN-1:0] rand_mask();
    logic [KEY_LEN-1:0] m;
    for (int i = 0; i < KEY_LEN; i++) m[i] = 1'($urandom_range(0, 1));
    return m;
  endfunction

  // Expected bus contents for one committed write: only the bits that reach the bus.
  function automatic logic [EXP_W-1:0] mk_rec(input logic [1:0] tgt, input logic [4:0] addr,
                                              input logic [ACT_W-1:0] data,
                                              input logic [KEY_LEN-1:0] mask);
    logic [ACT_W-1:0]   d;
    logic [KEY_LEN-1:0] m;
    d = '0;
    m = '0;
    if (tgt == 2'd0) for (int i = 0; i < KEY_OFF; i++) d[i] = data[i];
    if (tgt == 2'd1) begin
      for (int i = 0; i < KEY_LEN; i++) d[i] = data[i];
      m = mask;
    end
    if (tgt == 2'd2) d = data;
    return {tgt, addr, d, m};
  endfunction

  // Scoreboard: every strobe pops one expected record.
  always @(negedge axis_clk) begin
    if (key_off_entry_valid || lookup_din_en || action_en) begin
      checks++;
      obs_rec = '0;
      if (key_off_entry_valid)
        obs_rec = {2'd0, key_off_entry_addr, {(ACT_W-KEY_OFF){1'b0}}, key_off_entry_out, {KEY_LEN{1'b0}}};
      if (lookup_din_en)
        obs_rec = {2'd1, lookup_din_addr, {(ACT_W-KEY_LEN){1'b0}}, lookup_din, lookup_din_mask};
      if (action_en)
        obs_rec = {2'd2, action_addr, action_data_out, {KEY_LEN{1'b0}}};
      if (int'(key_off_entry_valid) + int'(lookup_din_en) + int'(action_en) > 1) begin
        errors++;
        $display("FAIL multi_strobe got=%b%b%b exp=one-hot", key_off_entry_valid, lookup_din_en, action_en);
      end else if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_strobe got tgt=%0d addr=%0d exp=no write", obs_rec[EXP_W-1 -: 2], obs_rec[EXP_W-3 -: 5]);
      end else begin
        exp_rec = exp_q.pop_front();
        if (obs_rec !== exp_rec) begin
          errors++;
          $display("FAIL write_record got=%h exp=%h", obs_rec, exp_rec);
        end
      end
    end
  end

  // Driver tasks: all start and end 1 time unit after a rising edge.
  task automatic tick();
    @(posedge axis_clk);
    #1;
  endtask

  task automatic send_cmd(input logic [2:0] stg, input logic [1:0] tgt, input logic [4:0] addr,
                          input logic [ACT_W-1:0] data, input logic [KEY_LEN-1:0] mask,
                          input bit expect_wr);
    cfg_valid  = 1'b1;
    cfg_stage  = stg;
    cfg_target = tgt;
    cfg_addr   = addr;
    cfg_data   = data;
    cfg_mask   = mask;
    if (expect_wr) begin
      exp_q.push_back(mk_rec(tgt, addr, data, mask));
      exp_wr++;
    end
    tick();
    cfg_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 60 && !ok; i++) begin
      @(negedge axis_clk);
      if (cfg_ready === 1'b1 && state_dbg === 2'd0) ok = 1'b1;
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s_idle_timeout got state=%0d exp=0 within 60 cycles", name, state_dbg);
    end
    tick();
  endtask

  task automatic test_reset();
    aresetn = 1'b0;
    cfg_valid = 1'b0; cfg_stage = '0; cfg_target = '0; cfg_addr = '0;
    cfg_data = '0; cfg_mask = '0; phv_in_valid = 1'b0; phv_out_valid = 1'b0;
    exp_wr = 0;
    repeat (3) tick();
    @(negedge axis_clk);
    checks++;
    if ({cfg_ready, cfg_done, cfg_err, phv_hold, key_off_entry_valid, lookup_din_en, action_en} !== 7'b1000000) begin
      errors++;
      $display("FAIL reset_ctrl got=%b exp=1000000", {cfg_ready, cfg_done, cfg_err, phv_hold, key_off_entry_valid, lookup_din_en, action_en});
    end
    checks++;
    if (wr_count !== 16'd0 || state_dbg !== 2'd0) begin
      errors++;
      $display("FAIL reset_count got wr=%0d st=%0d exp wr=0 st=0", wr_count, state_dbg);
    end
    checks++;
    if ({key_off_entry_out, key_off_entry_addr, lookup_din, lookup_din_mask, lookup_din_addr,
         action_data_out, action_addr} !== '0) begin
      errors++;
      $display("FAIL reset_buses got=nonzero exp=0");
    end
    tick();
    aresetn = 1'b1;
    @(negedge axis_clk);
    checks++;
    if (cfg_ready !== 1'b1 || phv_hold !== 1'b0) begin
      errors++;
      $display("FAIL reset_release got rdy=%b hold=%b exp rdy=1 hold=0", cfg_ready, phv_hold);
    end
    tick();
  endtask

  task automatic test_action_write();
    last_act_data = rand_data();
    send_cmd(3'd2, 2'd2, 5'd5, last_act_data, rand_mask(), 1'b1);
    @(negedge axis_clk);
    checks++;
    if ({phv_hold, cfg_ready, action_en, state_dbg} !== {1'b1, 1'b0, 1'b0, 2'd1}) begin
      errors++;
      $display("FAIL act_drain got hold=%b rdy=%b en=%b st=%0d exp 1 0 0 1", phv_hold, cfg_ready, action_en, state_dbg);
    end
    @(negedge axis_clk);
    checks++;
    if (action_en !== 1'b1 || action_addr !== 5'd5 || cfg_done !== 1'b0) begin
      errors++;
      $display("FAIL act_strobe got en=%b addr=%0d done=%b exp en=1 addr=5 done=0", action_en, action_addr, cfg_done);
    end
    @(negedge axis_clk);
    checks++;
    if (action_en !== 1'b0 || cfg_done !== 1'b1) begin
      errors++;
      $display("FAIL act_done got en=%b done=%b exp en=0 done=1", action_en, cfg_done);
    end
    @(negedge axis_clk);
    checks++;
    if (cfg_done !== 1'b0 || wr_count !== 16'd1 || cfg_ready !== 1'b1) begin
      errors++;
      $display("FAIL act_after got done=%b wr=%0d rdy=%b exp done=0 wr=1 rdy=1", cfg_done, wr_count, cfg_ready);
    end
    tick();
  endtask

  task automatic test_key_off();
    send_cmd(3'd2, 2'd0, 5'd17, rand_data(), rand_mask(), 1'b1);
    wait_idle("keyoff");
    checks++;
    if (wr_count !== 16'(exp_wr)) begin
      errors++;
      $display("FAIL keyoff_count got=%0d exp=%0d", wr_count, exp_wr);
    end
    checks++;
    if (action_addr !== 5'd5 || action_data_out !== last_act_data) begin
      errors++;
      $display("FAIL action_hold got addr=%0d exp addr=5 (data held)", action_addr);
    end
  endtask

  task automatic test_lookup_drain();
    phv_in_valid = 1'b1;
    repeat (3) tick();
    phv_in_valid = 1'b0;
    send_cmd(3'd2, 2'd1, 5'd9, rand_data(), rand_mask(), 1'b1);
    for (int i = 0; i < 5; i++) begin
      if (i >= 2) phv_out_valid = 1'b1;
      @(negedge axis_clk);
      checks++;
      if (lookup_din_en !== 1'b0 || phv_hold !== 1'b1) begin
        errors++;
        $display("FAIL lookup_wait%0d got en=%b hold=%b exp en=0 hold=1", i, lookup_din_en, phv_hold);
      end
      tick();
    end
    phv_out_valid = 1'b0;
    @(negedge axis_clk);
    checks++;
    if (lookup_din_en !== 1'b0 || state_dbg !== 2'd1) begin
      errors++;
      $display("FAIL lookup_last_drain got en=%b st=%0d exp en=0 st=1", lookup_din_en, state_dbg);
    end
    @(negedge axis_clk);
    checks++;
    if (lookup_din_en !== 1'b1 || lookup_din_addr !== 5'd9) begin
      errors++;
      $display("FAIL lookup_strobe got en=%b addr=%0d exp en=1 addr=9", lookup_din_en, lookup_din_addr);
    end
    wait_idle("lookup");
  endtask

  task automatic test_both_strobes();
    phv_in_valid = 1'b1;
    tick();
    phv_in_valid = 1'b0;
    send_cmd(3'd2, 2'd0, 5'd3, rand_data(), rand_mask(), 1'b1);
    phv_in_valid  = 1'b1;
    phv_out_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge axis_clk);
      checks++;
      if (state_dbg !== 2'd1 || key_off_entry_valid !== 1'b0) begin
        errors++;
        $display("FAIL both_drain%0d got st=%0d en=%b exp st=1 en=0", i, state_dbg, key_off_entry_valid);
      end
      tick();
    end
    phv_in_valid = 1'b0;
    @(negedge axis_clk);
    checks++;
    if (state_dbg !== 2'd1) begin
      errors++;
      $display("FAIL both_count_kept got st=%0d exp st=1", state_dbg);
    end
    tick();
    phv_out_valid = 1'b0;
    @(negedge axis_clk);
    checks++;
    if (state_dbg !== 2'd1 || key_off_entry_valid !== 1'b0) begin
      errors++;
      $display("FAIL both_pre_write got st=%0d en=%b exp st=1 en=0", state_dbg, key_off_entry_valid);
    end
    @(negedge axis_clk);
    checks++;
    if (key_off_entry_valid !== 1'b1 || key_off_entry_addr !== 5'd3) begin
      errors++;
      $display("FAIL both_write got en=%b addr=%0d exp en=1 addr=3", key_off_entry_valid, key_off_entry_addr);
    end
    wait_idle("both");
  endtask

  task automatic test_drop();
    send_cmd(3'd4, 2'd2, 5'd11, rand_data(), rand_mask(), 1'b0);
    for (int i = 0; i < 4; i++) begin
      @(negedge axis_clk);
      checks++;
      if (cfg_ready !== 1'b1 || phv_hold !== 1'b0 || state_dbg !== 2'd0 || action_addr !== 5'd5) begin
        errors++;
        $display("FAIL drop%0d got rdy=%b hold=%b st=%0d addr=%0d exp 1 0 0 5", i, cfg_ready, phv_hold, state_dbg, action_addr);
      end
      tick();
    end
    checks++;
    if (wr_count !== 16'(exp_wr)) begin
      errors++;
      $display("FAIL drop_count got=%0d exp=%0d", wr_count, exp_wr);
    end
  endtask

  task automatic test_err();
    send_cmd(3'd2, 2'd3, 5'd7, rand_data(), rand_mask(), 1'b0);
    @(negedge axis_clk);
    checks++;
    if ({cfg_err, cfg_ready, cfg_done, state_dbg} !== {1'b1, 1'b1, 1'b0, 2'd0}) begin
      errors++;
      $display("FAIL err_pulse got err=%b rdy=%b done=%b st=%0d exp 1 1 0 0", cfg_err, cfg_ready, cfg_done, state_dbg);
    end
    @(negedge axis_clk);
    checks++;
    if (cfg_err !== 1'b0 || cfg_done !== 1'b0) begin
      errors++;
      $display("FAIL err_single got err=%b done=%b exp err=0 done=0", cfg_err, cfg_done);
    end
    tick();
  endtask

  task automatic test_reset_drain();
    phv_in_valid = 1'b1;
    tick();
    phv_in_valid = 1'b0;
    send_cmd(3'd2, 2'd0, 5'd21, rand_data(), rand_mask(), 1'b0);
    @(negedge axis_clk);
    checks++;
    if (state_dbg !== 2'd1) begin
      errors++;
      $display("FAIL rst_pre_drain got st=%0d exp st=1", state_dbg);
    end
    aresetn = 1'b0;
    exp_wr = 0;
    #2;
    checks++;
    if (phv_hold !== 1'b0 || wr_count !== 16'd0 || state_dbg !== 2'd0 || key_off_entry_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_async got hold=%b wr=%0d st=%0d en=%b exp 0 0 0 0", phv_hold, wr_count, state_dbg, key_off_entry_valid);
    end
    tick();
    aresetn = 1'b1;
    @(negedge axis_clk);
    checks++;
    if (cfg_ready !== 1'b1 || phv_hold !== 1'b0) begin
      errors++;
      $display("FAIL rst_release got rdy=%b hold=%b exp rdy=1 hold=0", cfg_ready, phv_hold);
    end
    repeat (5) tick();
    checks++;
    if (wr_count !== 16'd0) begin
      errors++;
      $display("FAIL rst_no_commit got wr=%0d exp wr=0", wr_count);
    end
  endtask

  task automatic test_back_to_back();
    int n;
    for (int k = 0; k < 10; k++) begin
      n = $urandom_range(0, 3);
      phv_in_valid = (n != 0);
      repeat (n) tick();
      phv_in_valid = 1'b0;
      send_cmd(3'd2, 2'($urandom_range(0, 2)), 5'($urandom_range(0, 31)), rand_data(), rand_mask(), 1'b1);
      phv_out_valid = (n != 0);
      repeat (n) tick();
      phv_out_valid = 1'b0;
      wait_idle("b2b");
    end
    checks++;
    if (wr_count !== 16'(exp_wr)) begin
      errors++;
      $display("FAIL b2b_count got=%0d exp=%0d", wr_count, exp_wr);
    end
  endtask

  initial begin
    test_reset();
    test_action_write();
    test_key_off();
    test_lookup_drain();
    test_both_strobes();
    test_drop();
    test_err();
    test_reset_drain();
    test_back_to_back();
    repeat (3) tick();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got=%0d pending exp=0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
